// File: rtl/keypad_scan_encoder.sv
// ---------------------------------------------------------------------------
// keypad_scan_encoder
//   Scans a 4x4 active-low keypad matrix one column at a time, classifies each
//   four-column frame as NONE / SINGLE(code) / MULTI, and debounces the frame
//   stream into an accepted key code with press and release strobes.
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   row_n        in   4  keypad rows, active low, asynchronous to clk
//   col_n        out  4  column drive, one-hot-low
//   key          out  4  last accepted key code (held after release)
//   key_valid    out  1  one-cycle pulse on acceptance of a new key
//   key_held     out  1  high from key acceptance until release acceptance
//   key_release  out  1  one-cycle pulse on release acceptance
//   multi_key    out  1  high while the last completed frame saw >= 2 keys
//
// Debounce FSM
//   state   | meaning
//   IDLE    | no key accepted; qualifying SINGLE frames for a candidate
//   HELD    | key accepted; counting NONE frames toward release, or
//           | qualifying a different single key for direct rollover
// ---------------------------------------------------------------------------
module keypad_scan_encoder #(
    parameter int SCAN_CYCLES    = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held,
    output logic       key_release,
    output logic       multi_key
);

    localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DB_TARGET  = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

    localparam logic [1:0] FR_NONE   = 2'd0;
    localparam logic [1:0] FR_SINGLE = 2'd1;
    localparam logic [1:0] FR_MULTI  = 2'd2;

    logic [3:0]    row_meta_q, row_sync_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    hit_cnt_q, hit_cnt_d;
    logic [3:0]    hit_code_q, hit_code_d;
    logic          multi_key_q, multi_key_d;
    logic [0:0]    state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [3:0]    key_q, key_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
    logic          key_release_q, key_release_d;

    logic          sample, frame_end;
    logic [2:0]    col_hits, tot_hits;
    logic [3:0]    col_code, frame_code;
    logic [1:0]    frame_kind;
    logic [CW-1:0] pcnt_inc, rcnt_inc, pcnt_next;
    logic [3:0]    cand_next;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    always_comb begin
        sample    = (dwell_q == DWELL_LAST);
        frame_end = sample && (col_q == 2'd3);
        dwell_d   = sample ? '0 : dwell_q + 1'b1;
        col_d     = sample ? col_q + 2'd1 : col_q;

        col_hits = '0;
        col_code = '0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync_q[r]) begin
                col_hits = col_hits + 3'd1;
                col_code = key_code(2'(r), col_q);
            end
        end
        tot_hits   = {1'b0, hit_cnt_q} + col_hits;
        frame_code = (col_hits != 3'd0) ? col_code : hit_code_q;

        if (tot_hits == 3'd0)      frame_kind = FR_NONE;
        else if (tot_hits == 3'd1) frame_kind = FR_SINGLE;
        else                       frame_kind = FR_MULTI;

        // Per-frame accumulator only needs to distinguish 0, 1 and >=2 hits.
        hit_cnt_d  = hit_cnt_q;
        hit_code_d = hit_code_q;
        if (frame_end) begin
            hit_cnt_d  = '0;
            hit_code_d = '0;
        end else if (sample) begin
            hit_cnt_d  = (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
            hit_code_d = frame_code;
        end

        multi_key_d = frame_end ? (frame_kind == FR_MULTI) : multi_key_q;

        pcnt_inc  = (pcnt_q == DB_TARGET) ? pcnt_q : pcnt_q + 1'b1;
        rcnt_inc  = (rcnt_q == DB_TARGET) ? rcnt_q : rcnt_q + 1'b1;
        cand_next = frame_code;
        pcnt_next = (frame_code == cand_q) ? pcnt_inc : CNT_ONE;

        state_d       = state_q;
        cand_d        = cand_q;
        pcnt_d        = pcnt_q;
        rcnt_d        = rcnt_q;
        key_d         = key_q;
        key_held_d    = key_held_q;
        key_valid_d   = 1'b0;
        key_release_d = 1'b0;

        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_kind == FR_SINGLE) begin
                        cand_d = cand_next;
                        if (pcnt_next >= DB_TARGET) begin
                            key_d       = frame_code;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            state_d     = ST_HELD;
                            pcnt_d      = '0;
                        end else begin
                            pcnt_d = pcnt_next;
                        end
                    end else begin
                        pcnt_d = '0;
                    end
                end
                default: begin
                    if (frame_kind == FR_NONE) begin
                        pcnt_d = '0;
                        if (rcnt_inc >= DB_TARGET) begin
                            key_release_d = 1'b1;
                            key_held_d    = 1'b0;
                            state_d       = ST_IDLE;
                            rcnt_d        = '0;
                        end else begin
                            rcnt_d = rcnt_inc;
                        end
                    end else if (frame_kind == FR_SINGLE) begin
                        rcnt_d = '0;
                        if (frame_code == key_q) begin
                            // Bounce back onto the held key breaks any rollover run.
                            pcnt_d = '0;
                        end else begin
                            cand_d = cand_next;
                            if (pcnt_next >= DB_TARGET) begin
                                key_d       = frame_code;
                                key_valid_d = 1'b1;
                                pcnt_d      = '0;
                            end else begin
                                pcnt_d = pcnt_next;
                            end
                        end
                    end else begin
                        rcnt_d = '0;
                        pcnt_d = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q    <= 4'hF;
            row_sync_q    <= 4'hF;
            dwell_q       <= '0;
            col_q         <= '0;
            hit_cnt_q     <= '0;
            hit_code_q    <= '0;
            multi_key_q   <= 1'b0;
            state_q       <= ST_IDLE;
            cand_q        <= '0;
            pcnt_q        <= '0;
            rcnt_q        <= '0;
            key_q         <= '0;
            key_valid_q   <= 1'b0;
            key_held_q    <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            row_meta_q    <= row_n;
            row_sync_q    <= row_meta_q;
            dwell_q       <= dwell_d;
            col_q         <= col_d;
            hit_cnt_q     <= hit_cnt_d;
            hit_code_q    <= hit_code_d;
            multi_key_q   <= multi_key_d;
            state_q       <= state_d;
            cand_q        <= cand_d;
            pcnt_q        <= pcnt_d;
            rcnt_q        <= rcnt_d;
            key_q         <= key_d;
            key_valid_q   <= key_valid_d;
            key_held_q    <= key_held_d;
            key_release_q <= key_release_d;
        end
    end

    assign col_n       = ~(4'b0001 << col_q);
    assign key         = key_q;
    assign key_valid   = key_valid_q;
    assign key_held    = key_held_q;
    assign key_release = key_release_q;
    assign multi_key   = multi_key_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
module tb_keypad_scan_encoder;

    localparam int SC    = 8;
    localparam int DB    = 3;
    localparam int FRAME = 4 * SC;
    localparam int LAT   = DB * FRAME;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key;
    logic       key_valid, key_held, key_release, multi_key;

    logic [15:0] pressed;
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        logic        rel;
        logic [3:0]  code;
        int unsigned at;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    keypad_scan_encoder #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_n       (row_n),
        .col_n       (col_n),
        .key         (key),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .key_release (key_release),
        .multi_key   (multi_key)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad: row r pulled low while its pressed key's column is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4 + c] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic rel, input logic [3:0] code);
        ev_t e;
        e.rel  = rel;
        e.code = code;
        e.at   = cyc + LAT;
        exp_q.push_back(e);
    endtask

    task automatic wait_frame_start();
        int n = 0;
        while (col_n != 4'b0111 && n < 100) begin @(negedge clk); n++; end
        while (col_n != 4'b1110 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("frame_timeout", n, 0);
    endtask

    task automatic wait_frames(input int k);
        for (int i = 0; i < k; i++) wait_frame_start();
    endtask

    // Scoreboard: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && (key_valid || key_release)) begin
            chk("valid_release_overlap", {31'd0, key_valid & key_release}, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {30'd0, key_valid, key_release}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe_kind", {31'd0, key_release}, {31'd0, mon_e.rel});
                chk("strobe_cycle", cyc, mon_e.at);
                if (key_valid) chk("strobe_key", {28'd0, key}, {28'd0, mon_e.code});
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        pressed = '0;
        repeat (3) @(negedge clk);
        chk("rst_col_n", {28'd0, col_n}, 32'hE);
        chk("rst_key", {28'd0, key}, 0);
        chk("rst_flags", {28'd0, key_valid, key_held, key_release, multi_key}, 0);

        // 1: idle scan sequence
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            chk("scan_col_n", {28'd0, col_n}, {28'd0, ~(4'b0001 << ((i / SC) % 4))});
            @(negedge clk);
        end
        chk("idle_held", {31'd0, key_held}, 0);

        // 2: hold F
        wait_frame_start();
        pressed[3*4 + 1] = 1'b1;
        push(1'b0, 4'hF);
        wait_frames(5);
        chk("f_held", {31'd0, key_held}, 1);
        chk("f_key", {28'd0, key}, 32'hF);
        chk("f_pending", exp_q.size(), 0);

        // 3: release bounce
        pressed = '0;
        wait_frames(2);
        pressed[3*4 + 1] = 1'b1;
        wait_frames(1);
        pressed = '0;
        push(1'b1, 4'hF);
        wait_frames(4);
        chk("f_released", {31'd0, key_held}, 0);
        chk("f_key_kept", {28'd0, key}, 32'hF);
        chk("f_rel_pending", exp_q.size(), 0);

        // 4: multi-key while holding 5
        pressed[1*4 + 1] = 1'b1;
        push(1'b0, 4'h5);
        wait_frames(4);
        pressed[2*4 + 2] = 1'b1;
        wait_frames(1);
        chk("multi_on", {31'd0, multi_key}, 1);
        chk("multi_key_kept", {28'd0, key}, 32'h5);
        chk("multi_held", {31'd0, key_held}, 1);
        pressed[2*4 + 2] = 1'b0;
        wait_frames(1);
        chk("multi_off", {31'd0, multi_key}, 0);
        chk("multi_key_after", {28'd0, key}, 32'h5);
        pressed = '0;
        push(1'b1, 4'h5);
        wait_frames(4);

        // 5: rollover 1 -> 2
        pressed[0] = 1'b1;
        push(1'b0, 4'h1);
        wait_frames(4);
        pressed = '0;
        pressed[1] = 1'b1;
        push(1'b0, 4'h2);
        wait_frames(4);
        chk("roll_key", {28'd0, key}, 32'h2);
        chk("roll_held", {31'd0, key_held}, 1);
        pressed = '0;
        push(1'b1, 4'h2);
        wait_frames(4);

        // 6: reset mid-hold with E pressed
        pressed[3*4 + 2] = 1'b1;
        push(1'b0, 4'hE);
        wait_frames(4);
        chk("e_key", {28'd0, key}, 32'hE);
        repeat (13) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_col_n", {28'd0, col_n}, 32'hE);
        chk("mid_rst_key", {28'd0, key}, 0);
        chk("mid_rst_flags", {28'd0, key_valid, key_held, key_release, multi_key}, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        push(1'b0, 4'hE);
        wait_frames(4);
        chk("e_rekey", {28'd0, key}, 32'hE);
        chk("e_reheld", {31'd0, key_held}, 1);
        pressed = '0;
        push(1'b1, 4'hE);
        wait_frames(4);
        chk("final_pending", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
